// File: rtl/bram_pingpong_streamer.sv
// bram_pingpong_streamer
//   Streams DATA_W-bit elements from a combinational-read external memory,
//   packs LANES of them per word (lane 0 = first fetched, in the LSBs) and
//   writes the words into two internal BRAM banks used as ping-pong buffers.
//   One bank fills while the other drains onto a valid/ready output stream.
//
// Ports:
//   CLK, rst            clock, asynchronous active-high reset
//   start               begin a transfer (sampled only when idle)
//   src_base, length    first external address / packed words, captured on start
//   src_addr, src_rd_en external memory address and consume strobe
//   src_data            external data, valid in the same cycle as src_addr
//   out_valid/out_ready/out_data   packed word output stream
//   busy                transfer in progress
//   stall               fill blocked because both banks are full
//   complete            one-cycle pulse after the final output handshake
//   stall_cycles        (only with BSTREAM_STATS_EN) saturating count of stall cycles
//
// Handshake: a word transfers on every rising edge where out_valid && out_ready;
// while out_valid is high and out_ready low, out_data holds and out_valid stays.
//
// Optional feature macro: BSTREAM_STATS_EN adds the stall_cycles counter/port.
module bram_pingpong_streamer #(
    parameter int DATA_W     = 8,
    parameter int LANES      = 4,
    parameter int BANK_WORDS = 512,
    parameter int SRC_AW     = 18,
    parameter int LEN_W      = 16
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic                    start,
    input  logic [SRC_AW-1:0]       src_base,
    input  logic [LEN_W-1:0]        length,
    output logic [SRC_AW-1:0]       src_addr,
    output logic                    src_rd_en,
    input  logic [DATA_W-1:0]       src_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    busy,
    output logic                    stall,
`ifdef BSTREAM_STATS_EN
    output logic [31:0]             stall_cycles,
`endif
    output logic                    complete
);
    localparam int WORD_W = LANES * DATA_W;
    localparam int IDX_W  = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
    localparam int CNT_W  = IDX_W + 1;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(BANK_WORDS - 1);

    typedef enum logic [1:0] {F_IDLE, F_RUN, F_WAIT, F_DONE} fill_state_e;

    // Fill side
    fill_state_e         state_q, state_d;
    logic [SRC_AW-1:0]   src_addr_q, src_addr_d;
    logic [LEN_W-1:0]    length_q, length_d;
    logic [LEN_W-1:0]    words_q, words_d;
    logic [LANE_W-1:0]   lane_cnt_q, lane_cnt_d;
    logic [CNT_W-1:0]    fill_idx_q, fill_idx_d;
    logic [WORD_W-1:0]   word_q, word_d, asm_word;
    logic                fill_bank_q, fill_bank_d;
    logic [1:0]          bank_full_q, bank_full_d;
    logic [CNT_W-1:0]    bank_cnt_q [2];
    logic [CNT_W-1:0]    bank_cnt_d [2];
    logic                busy_q, busy_d, complete_q, complete_d;
    logic                start_accept, wr_word, last_word, bank_close;

    // Drain side
    logic                drain_bank_q;
    logic [CNT_W-1:0]    rd_idx_q, hs_cnt_q;
    logic [LEN_W-1:0]    hs_total_q;
    logic                rd_issue, rd_valid_q, hs, drain_done, final_hs;
    logic [WORD_W-1:0]   bram_dout_q;
    logic [WORD_W-1:0]   buf_q [2];
    logic                wr_ptr_q, rd_ptr_q;
    logic [1:0]          buf_cnt_q;

    logic [WORD_W-1:0]   bank_mem [2**(IDX_W+1)];

    assign start_accept = (state_q == F_IDLE) && start;
    assign wr_word      = (state_q == F_RUN) && (lane_cnt_q == LAST_LANE);
    assign last_word    = wr_word && (words_q + LEN_W'(1) == length_q);
    assign bank_close   = wr_word && (last_word || fill_idx_q == LAST_IDX);

    assign out_valid  = (buf_cnt_q != 2'd0);
    assign out_data   = buf_q[rd_ptr_q];
    assign hs         = out_valid && out_ready;
    assign drain_done = hs && (hs_cnt_q + CNT_W'(1) == bank_cnt_q[drain_bank_q]);
    assign final_hs   = hs && (hs_total_q + LEN_W'(1) == length_q);

    // A read is only issued when its word is guaranteed a buffer slot: words
    // already buffered plus the one in the BRAM output register, minus the one
    // leaving this cycle, must leave room.
    assign rd_issue = bank_full_q[drain_bank_q]
                   && (rd_idx_q != bank_cnt_q[drain_bank_q])
                   && (({1'b0, buf_cnt_q} + {2'b00, rd_valid_q}) <= (hs ? 3'd2 : 3'd1));

    assign src_addr  = src_addr_q;
    assign src_rd_en = (state_q == F_RUN);
    assign stall     = (state_q == F_WAIT);
    assign busy      = busy_q;
    assign complete  = complete_q;

    always_comb begin
        asm_word = word_q;
        asm_word[int'(lane_cnt_q) * DATA_W +: DATA_W] = src_data;
    end

    always_comb begin
        state_d     = state_q;
        src_addr_d  = src_addr_q;
        length_d    = length_q;
        words_d     = words_q;
        lane_cnt_d  = lane_cnt_q;
        fill_idx_d  = fill_idx_q;
        word_d      = word_q;
        fill_bank_d = fill_bank_q;
        bank_cnt_d  = bank_cnt_q;
        busy_d      = busy_q;
        complete_d  = 1'b0;
        case (state_q)
            F_IDLE: begin
                if (start) begin
                    src_addr_d = src_base;
                    length_d   = length;
                    words_d    = '0;
                    lane_cnt_d = '0;
                    fill_idx_d = '0;
                    word_d     = '0;
                    if (length == '0) begin
                        complete_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = F_RUN;
                    end
                end
            end
            F_RUN: begin
                src_addr_d = src_addr_q + SRC_AW'(1);
                word_d     = asm_word;
                lane_cnt_d = (lane_cnt_q == LAST_LANE) ? '0 : lane_cnt_q + LANE_W'(1);
                if (wr_word) begin
                    words_d    = words_q + LEN_W'(1);
                    fill_idx_d = fill_idx_q + CNT_W'(1);
                end
                if (bank_close) begin
                    bank_cnt_d[fill_bank_q] = fill_idx_q + CNT_W'(1);
                    fill_idx_d  = '0;
                    fill_bank_d = ~fill_bank_q;
                    if (last_word) begin
                        state_d = F_DONE;
                    end else if (bank_full_q[~fill_bank_q]) begin
                        state_d = F_WAIT;
                    end
                end
            end
            F_WAIT: begin
                if (!bank_full_q[fill_bank_q]) state_d = F_RUN;
            end
            F_DONE: begin
                state_d = F_DONE;
            end
            default: state_d = F_IDLE;
        endcase
        if (final_hs) begin
            state_d    = F_IDLE;
            busy_d     = 1'b0;
            complete_d = 1'b1;
        end
    end

    // Fill closes fill_bank while drain frees drain_bank; they are never the
    // same bank, so both updates apply in the same cycle.
    always_comb begin
        bank_full_d = bank_full_q;
        if (bank_close) bank_full_d[fill_bank_q]  = 1'b1;
        if (drain_done) bank_full_d[drain_bank_q] = 1'b0;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q       <= F_IDLE;
            src_addr_q    <= '0;
            length_q      <= '0;
            words_q       <= '0;
            lane_cnt_q    <= '0;
            fill_idx_q    <= '0;
            word_q        <= '0;
            fill_bank_q   <= 1'b0;
            bank_full_q   <= 2'b00;
            bank_cnt_q[0] <= '0;
            bank_cnt_q[1] <= '0;
            busy_q        <= 1'b0;
            complete_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_addr_q  <= src_addr_d;
            length_q    <= length_d;
            words_q     <= words_d;
            lane_cnt_q  <= lane_cnt_d;
            fill_idx_q  <= fill_idx_d;
            word_q      <= word_d;
            fill_bank_q <= fill_bank_d;
            bank_full_q <= bank_full_d;
            bank_cnt_q  <= bank_cnt_d;
            busy_q      <= busy_d;
            complete_q  <= complete_d;
        end
    end

    // Both banks share one array; the bank select is the top address bit.
    always_ff @(posedge CLK) begin
        if (wr_word)  bank_mem[{fill_bank_q, fill_idx_q[IDX_W-1:0]}] <= asm_word;
        if (rd_issue) bram_dout_q <= bank_mem[{drain_bank_q, rd_idx_q[IDX_W-1:0]}];
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            drain_bank_q <= 1'b0;
            rd_idx_q     <= '0;
            hs_cnt_q     <= '0;
            hs_total_q   <= '0;
            rd_valid_q   <= 1'b0;
            buf_q[0]     <= '0;
            buf_q[1]     <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            buf_cnt_q    <= 2'd0;
        end else begin
            rd_valid_q <= rd_issue;
            if (rd_issue) rd_idx_q <= rd_idx_q + CNT_W'(1);
            if (rd_valid_q) begin
                buf_q[wr_ptr_q] <= bram_dout_q;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (hs) begin
                rd_ptr_q   <= ~rd_ptr_q;
                hs_cnt_q   <= hs_cnt_q + CNT_W'(1);
                hs_total_q <= hs_total_q + LEN_W'(1);
            end
            buf_cnt_q <= buf_cnt_q + {1'b0, rd_valid_q} - {1'b0, hs};
            if (drain_done) begin
                drain_bank_q <= ~drain_bank_q;
                rd_idx_q     <= '0;
                hs_cnt_q     <= '0;
            end
            if (start_accept) hs_total_q <= '0;
        end
    end

`ifdef BSTREAM_STATS_EN
    logic [31:0] stall_cycles_q;
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else if (start_accept) begin
            stall_cycles_q <= '0;
        end else if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end
    assign stall_cycles = stall_cycles_q;
`endif

endmodule
